// File: rtl/route_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : route_arbiter
// Description : Per-output round-robin route reservation for an N-port
//               switch. Each input may claim one output and keep it until it
//               relieves it. Outputs are registered crossbar selects and busy
//               flags.
// Revision    : 1.0 - initial release
// ============================================================================
module route_arbiter #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               routeReserveRequestValid,
    input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [N-1:0]               routeRelieve,
    output logic [N-1:0]               routeReserveStatus,
    output logic [N*REQUEST_WIDTH-1:0] outSelect,
    output logic [N-1:0]               outBusy
);

    // Each output is either free or owned by exactly one input.
    typedef enum logic [0:0] {
        S_FREE  = 1'b0,
        S_OWNED = 1'b1
    } out_state_t;

    out_state_t               r_state          [N];
    out_state_t               w_state_next     [N];
    logic [REQUEST_WIDTH-1:0] r_owner          [N];
    logic [REQUEST_WIDTH-1:0] w_owner_next     [N];
    logic [REQUEST_WIDTH-1:0] r_rr             [N];
    logic [REQUEST_WIDTH-1:0] w_rr_next        [N];
    logic [REQUEST_WIDTH-1:0] r_held_port      [N];
    logic [REQUEST_WIDTH-1:0] w_held_port_next [N];
    logic [N-1:0]             r_held;
    logic [N-1:0]             w_held_next;

    // w_eligible[j][i]: input i may be granted output j this cycle.
    logic [N-1:0]             w_eligible       [N];
    logic [N-1:0]             w_grant_valid;
    logic [REQUEST_WIDTH-1:0] w_grant_idx      [N];

    // Eligibility: valid request for this output, not already holding, not relieving.
    // Codes >= N never match any output index, so they are ignored naturally.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_eligible[j] = '0;
            for (int i = 0; i < N; i++) begin
                if (routeReserveRequestValid[i] && !r_held[i] && !routeRelieve[i] &&
                    (int'(routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]) == j)) begin
                    w_eligible[j][i] = 1'b1;
                end
            end
        end
    end

    // Round-robin search per free output, starting at rr[j] and wrapping modulo N.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_grant_valid[j] = 1'b0;
            w_grant_idx[j]   = '0;
            if (r_state[j] == S_FREE) begin
                for (int k = 0; k < N; k++) begin
                    for (int i = 0; i < N; i++) begin
                        if (!w_grant_valid[j] && w_eligible[j][i] &&
                            (i == ((int'(r_rr[j]) + k) % N))) begin
                            w_grant_valid[j] = 1'b1;
                            w_grant_idx[j]   = REQUEST_WIDTH'(i);
                        end
                    end
                end
            end
        end
    end

    // Next-state: apply grants and relieves. A relieve only touches an owned
    // output and a grant only a free one, so they never collide.
    always_comb begin
        w_held_next = r_held;
        for (int j = 0; j < N; j++) begin
            w_state_next[j]     = r_state[j];
            w_owner_next[j]     = r_owner[j];
            w_rr_next[j]        = r_rr[j];
            w_held_port_next[j] = r_held_port[j];
        end

        for (int j = 0; j < N; j++) begin
            if (w_grant_valid[j]) begin
                w_state_next[j] = S_OWNED;
                w_owner_next[j] = w_grant_idx[j];
                for (int i = 0; i < N; i++) begin
                    if (int'(w_grant_idx[j]) == i) begin
                        w_rr_next[j]        = REQUEST_WIDTH'((i + 1) % N);
                        w_held_next[i]      = 1'b1;
                        w_held_port_next[i] = REQUEST_WIDTH'(j);
                    end
                end
            end
        end

        for (int i = 0; i < N; i++) begin
            if (r_held[i] && routeRelieve[i]) begin
                w_held_next[i] = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (int'(r_held_port[i]) == j) begin
                        w_state_next[j] = S_FREE;
                    end
                end
            end
        end
    end

    // State registers; reset drops every ownership and rewinds the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= '0;
            for (int j = 0; j < N; j++) begin
                r_state[j]     <= S_FREE;
                r_owner[j]     <= '0;
                r_rr[j]        <= '0;
                r_held_port[j] <= '0;
            end
        end else begin
            r_held <= w_held_next;
            for (int j = 0; j < N; j++) begin
                r_state[j]     <= w_state_next[j];
                r_owner[j]     <= w_owner_next[j];
                r_rr[j]        <= w_rr_next[j];
                r_held_port[j] <= w_held_port_next[j];
            end
        end
    end

    assign routeReserveStatus = r_held;

    generate
        for (genvar j = 0; j < N; j++) begin : g_out
            assign outSelect[j*REQUEST_WIDTH +: REQUEST_WIDTH] = r_owner[j];
            assign outBusy[j] = (r_state[j] == S_OWNED);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_route_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_route_arbiter
// Description : Self-checking bench for route_arbiter: directed scenarios plus
//               randomized traffic against an ownership-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_route_arbiter;

    localparam int N  = 4;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  valid;
    logic [N*RW-1:0] req;
    logic [N-1:0]  relieve;
    logic [N-1:0]  status;
    logic [N*RW-1:0] sel;
    logic [N-1:0]  busy;

    int n_cmp = 0;
    int n_err = 0;

    route_arbiter #(.N(N), .REQUEST_WIDTH(RW)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (valid),
        .routeReserveRequest      (req),
        .routeRelieve             (relieve),
        .routeReserveStatus       (status),
        .outSelect                (sel),
        .outBusy                  (busy)
    );

    always #5 clk = ~clk;

    // Model: which input owns each output (-1 free), which output each input
    // holds (-1 none), last owner per output (mux select) and rr pointer.
    int m_owner [N];
    int m_port  [N];
    int m_sel   [N];
    int m_rr    [N];

    function automatic void model_reset();
        for (int j = 0; j < N; j++) begin
            m_owner[j] = -1;
            m_port[j]  = -1;
            m_sel[j]   = 0;
            m_rr[j]    = 0;
        end
    endfunction

    function automatic void model_step();
        int n_owner [N];
        int n_port  [N];
        int n_rr    [N];
        int cand;
        bit done;
        n_owner = m_owner;
        n_port  = m_port;
        n_rr    = m_rr;
        for (int j = 0; j < N; j++) begin
            if (m_owner[j] < 0) begin
                done = 1'b0;
                for (int k = 0; k < N; k++) begin
                    cand = (m_rr[j] + k) % N;
                    if (!done && valid[cand] && int'(req[cand*RW +: RW]) == j &&
                        m_port[cand] < 0 && !relieve[cand]) begin
                        done          = 1'b1;
                        n_owner[j]    = cand;
                        m_sel[j]      = cand;
                        n_rr[j]       = (cand + 1) % N;
                        n_port[cand]  = j;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_port[i] >= 0 && relieve[i]) begin
                n_owner[m_port[i]] = -1;
                n_port[i]          = -1;
            end
        end
        m_owner = n_owner;
        m_port  = n_port;
        m_rr    = n_rr;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*RW-1:0] r, input logic [N-1:0] rl);
        valid   = v;
        req     = r;
        relieve = rl;
    endtask

    // One clock: model advances on the edge, outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        drive('0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, '0);
        model_reset();
        #1;
        n_cmp++;
        if ({status, busy, sel} !== '0) begin
            n_err++;
            $display("FAIL reset_initial: got status=%b busy=%b sel=%h, expected all zero", status, busy, sel);
        end
        repeat (2) tick();
        n_cmp++;
        if ({status, busy, sel} !== '0) begin
            n_err++;
            $display("FAIL reset_held: got status=%b busy=%b sel=%h, expected all zero", status, busy, sel);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        drive(4'b0010, {2'd0, 2'd0, 2'd3, 2'd0}, '0);
        tick();
        n_cmp++;
        if ({status, busy} !== 8'b0010_1000) begin
            n_err++;
            $display("FAIL single_grant: got status=%b busy=%b, expected 0010 1000", status, busy);
        end
        n_cmp++;
        if (sel[7:6] !== 2'd1) begin
            n_err++;
            $display("FAIL single_select: got sel3=%0d, expected 1", sel[7:6]);
        end
        drive('0, '0, 4'b0010);
        tick();
        n_cmp++;
        if ({status, busy} !== 8'b0000_0000) begin
            n_err++;
            $display("FAIL single_relieve: got status=%b busy=%b, expected 0000 0000", status, busy);
        end
    endtask

    task automatic test_contention();
        logic [N*RW-1:0] all1;
        all1 = {2'd1, 2'd1, 2'd1, 2'd1};
        do_reset();
        drive(4'b1101, all1, '0);
        tick();
        n_cmp++;
        if ({status, busy, sel[3:2]} !== 10'b0001_0010_00) begin
            n_err++;
            $display("FAIL contend_first: got status=%b busy=%b sel1=%0d, expected 0001 0010 0", status, busy, sel[3:2]);
        end
        drive(4'b1100, all1, 4'b0001);
        tick();
        n_cmp++;
        if ({status, busy} !== 8'b0000_0000) begin
            n_err++;
            $display("FAIL contend_gap: got status=%b busy=%b, expected 0000 0000", status, busy);
        end
        drive(4'b1100, all1, '0);
        tick();
        n_cmp++;
        if ({status, busy, sel[3:2]} !== 10'b0100_0010_10) begin
            n_err++;
            $display("FAIL contend_second: got status=%b busy=%b sel1=%0d, expected 0100 0010 2", status, busy, sel[3:2]);
        end
        drive(4'b1000, all1, 4'b0100);
        tick();
        drive(4'b1000, all1, '0);
        tick();
        n_cmp++;
        if ({status, busy, sel[3:2]} !== 10'b1000_0010_11) begin
            n_err++;
            $display("FAIL contend_third: got status=%b busy=%b sel1=%0d, expected 1000 0010 3", status, busy, sel[3:2]);
        end
        // Pointer should now be back at 0: input 0 beats input 3.
        drive('0, all1, 4'b1000);
        tick();
        drive(4'b1001, all1, '0);
        tick();
        n_cmp++;
        if ({status, sel[3:2]} !== 6'b0001_00) begin
            n_err++;
            $display("FAIL contend_rr_wrap: got status=%b sel1=%0d, expected 0001 0", status, sel[3:2]);
        end
    endtask

    task automatic test_parallel();
        do_reset();
        drive(4'b0011, {2'd0, 2'd0, 2'd0, 2'd2}, '0);
        tick();
        n_cmp++;
        if ({status, busy} !== 8'b0011_0101) begin
            n_err++;
            $display("FAIL parallel_grant: got status=%b busy=%b, expected 0011 0101", status, busy);
        end
        n_cmp++;
        if ({sel[5:4], sel[1:0]} !== 4'b00_01) begin
            n_err++;
            $display("FAIL parallel_select: got sel2=%0d sel0=%0d, expected 0 1", sel[5:4], sel[1:0]);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        drive(4'b0100, '0, '0);
        tick();
        drive(4'b1000, '0, 4'b0100);
        tick();
        n_cmp++;
        if ({status, busy} !== 8'b0000_0000) begin
            n_err++;
            $display("FAIL overlap_t1: got status=%b busy=%b, expected 0000 0000", status, busy);
        end
        drive(4'b1000, '0, '0);
        tick();
        n_cmp++;
        if ({status, busy, sel[1:0]} !== 10'b1000_0001_11) begin
            n_err++;
            $display("FAIL overlap_t2: got status=%b busy=%b sel0=%0d, expected 1000 0001 3", status, busy, sel[1:0]);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        drive(4'b0010, {2'd0, 2'd0, 2'd2, 2'd0}, '0);
        tick();
        drive(4'b0010, {2'd0, 2'd0, 2'd3, 2'd0}, 4'b0001);
        tick();
        tick();
        n_cmp++;
        if ({status, busy, sel[5:4]} !== 10'b0010_0100_01) begin
            n_err++;
            $display("FAIL spurious: got status=%b busy=%b sel2=%0d, expected 0010 0100 1", status, busy, sel[5:4]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'b0111, {2'd0, 2'd3, 2'd2, 2'd1}, '0);
        tick();
        n_cmp++;
        if ({status, busy} !== 8'b0111_1110) begin
            n_err++;
            $display("FAIL async_setup: got status=%b busy=%b, expected 0111 1110", status, busy);
        end
        drive('0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({status, busy, sel} !== '0) begin
            n_err++;
            $display("FAIL async_immediate: got status=%b busy=%b sel=%h, expected all zero", status, busy, sel);
        end
        #1;
        rst = 1'b0;
        drive(4'b1000, '0, '0);
        tick();
        n_cmp++;
        if ({status, busy, sel[1:0]} !== 10'b1000_0001_11) begin
            n_err++;
            $display("FAIL async_regrant: got status=%b busy=%b sel0=%0d, expected 1000 0001 3", status, busy, sel[1:0]);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]    es;
        logic [N-1:0]    eb;
        logic [N*RW-1:0] esel;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive(N'($urandom), (N*RW)'($urandom), N'($urandom & $urandom));
            tick();
            for (int i = 0; i < N; i++) begin
                es[i]              = (m_port[i] >= 0);
                eb[i]              = (m_owner[i] >= 0);
                esel[i*RW +: RW]   = RW'(m_sel[i]);
            end
            n_cmp++;
            if ({status, busy, sel} !== {es, eb, esel}) begin
                n_err++;
                $display("FAIL random_cycle%0d: got status=%b busy=%b sel=%h, expected %b %b %h",
                         c, status, busy, sel, es, eb, esel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_parallel();
        test_overlap();
        test_spurious();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/route_arbiter.md
ROUTE_ARBITER -- requirements
Module: route_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of switch input ports and output ports.
REQ-002 SHALL have parameter REQUEST_WIDTH, default 2: width of one output-port request code (0 N, 1 S, 2 W, 3 E).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port routeReserveRequestValid, input, N bits: bit i set means input port i requests an output.
REQ-006 SHALL have port routeReserveRequest, input, N*REQUEST_WIDTH bits: slice i is the output index requested by input i.
REQ-007 SHALL have port routeRelieve, input, N bits: bit i set means input i releases the output it holds.
REQ-008 SHALL have port routeReserveStatus, output, N bits: bit i set means input i currently owns an output.
REQ-009 SHALL have port outSelect, output, N*REQUEST_WIDTH bits: slice j is the owner input index of output j, used as the crossbar mux select.
REQ-010 SHALL have port outBusy, output, N bits: bit j set means output j is owned.

Function
REQ-011 SHALL keep, per output j, a registered busy[j], a registered owner[j] (REQUEST_WIDTH bits) and a round-robin pointer rr[j] (REQUEST_WIDTH bits).
REQ-012 SHALL keep, per input i, a registered held[i] flag and a registered heldPort[i] index.
REQ-013 SHALL treat each output as a two-state FSM: FREE (busy=0) and OWNED (busy=1).
- FREE->OWNED on grant.
- OWNED->FREE on routeRelieve[owner].
REQ-014 SHALL make input i eligible for output j in cycle t only when all hold: valid[i]=1, request slice i equals j, held[i]=0, routeRelieve[i]=0.
REQ-015 SHALL grant a FREE output j, when at least one input is eligible, to the first eligible input found searching upward from rr[j] modulo N.
REQ-016 On grant of output j to input i, SHALL set at the next edge: busy[j]=1, owner[j]=i, rr[j]=(i+1) mod N, held[i]=1, heldPort[i]=j.
REQ-017 SHALL evaluate grants only from registered busy state; an output freed in cycle t is grantable from cycle t+1, never in cycle t.
REQ-018 SHALL drive routeReserveStatus[i]=held[i] as a registered level: high from the cycle after the grant until the cycle after the relieve (request-to-status latency is 1 cycle).
REQ-019 SHALL keep at most one grant per input per cycle; an input may request only one output, so no input is double-granted.
REQ-020 SHALL grant multiple outputs in the same cycle when distinct inputs are eligible for distinct free outputs.
REQ-021 On routeRelieve[i] with held[i]=1, SHALL clear held[i] and busy[heldPort[i]] at the next edge; owner and rr of that output are unchanged.
REQ-022 SHALL ignore routeRelieve[i] when held[i]=0.
REQ-023 SHALL ignore a request from input i while held[i]=1; the held output is unaffected.
REQ-024 SHALL ignore request codes >= N.
REQ-025 SHALL leave rr[j] unchanged in cycles with no grant for output j.
REQ-026 SHALL drive outSelect slice j = owner[j] and outBusy = busy; outSelect is meaningful only while busy[j]=1.
REQ-027 SHALL make outputs purely registered, with no combinational path from inputs to outputs.

Reset
REQ-028 While rst=1, SHALL asynchronously force: busy=0, held=0, owner=0, heldPort=0, rr=0, hence routeReserveStatus=0, outBusy=0, outSelect=0.
REQ-029 Reset asserted mid-packet SHALL drop all ownerships; no relieve is required afterwards, and the first grant after reset searches from input 0.

Verification
REQ-030 Single request: input 1 requests 3 at t -> t+1 routeReserveStatus=0010, outBusy=1000, outSelect slice3=1.
REQ-031 Contention: inputs 0,2,3 all request 1 with rr[1]=0 -> input 0 granted; after input 0 relieves, input 2 is granted 2 cycles after the relieve, then input 3 after input 2 relieves; rr[1] ends at 0.
REQ-032 Parallel grants: input 0 requests 2 and input 1 requests 0 in the same cycle -> next cycle status=0011, outBusy=0101.
REQ-033 Relieve/request overlap: input 2 holds 0, relieves at t while input 3 requests 0 at t and t+1 -> status[3]=1 at t+2, not t+1; outBusy[0]=0 at t+1.
REQ-034 Async reset: with 3 outputs owned, assert rst between edges -> all outputs 0 immediately, before the next edge; after release, input 3 requests 0 and is granted.
REQ-035 Spurious controls: relieve from an idle input and a second request from a holding input -> no state change.
